// File: rtl/pwm_ramp_pkg.sv
// Shared types and constants for the PWM duty ramp controller.
// Optional feature macro: PWM_RAMP_BYPASS_EN (adds an immediate-load bypass input).
package pwm_ramp_pkg;

    localparam int unsigned DUTY_W_DEF = 8;
    localparam int unsigned DIV_W_DEF  = 8;
    localparam int unsigned STEP_W_DEF = 4;

    // A programmed step of zero still has to make progress, so it is replaced by this value.
    localparam int unsigned ZERO_STEP_SUBST = 1;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } ramp_state_t;

endpackage

// File: rtl/pwm_ramp_controller_if.sv
// Configuration and status bundle between the register bank and the ramp controller.
// Optional feature macro: PWM_RAMP_BYPASS_EN (adds the bypass signal).
interface pwm_ramp_controller_if
    import pwm_ramp_pkg::*;
#(
    parameter int unsigned DUTY_W = DUTY_W_DEF,
    parameter int unsigned DIV_W  = DIV_W_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
);

`ifdef PWM_RAMP_BYPASS_EN
    logic              bypass;
`endif
    logic              enable;
    logic              cfg_valid;
    logic [DUTY_W-1:0] cfg_target;
    logic [STEP_W-1:0] cfg_step;
    logic [DIV_W-1:0]  cfg_div;
    logic [DUTY_W-1:0] duty_out;
    logic              busy;
    logic              done;

    modport master (
`ifdef PWM_RAMP_BYPASS_EN
        output bypass,
`endif
        output enable,
        output cfg_valid,
        output cfg_target,
        output cfg_step,
        output cfg_div,
        input  duty_out,
        input  busy,
        input  done
    );

    modport slave (
`ifdef PWM_RAMP_BYPASS_EN
        input  bypass,
`endif
        input  enable,
        input  cfg_valid,
        input  cfg_target,
        input  cfg_step,
        input  cfg_div,
        output duty_out,
        output busy,
        output done
    );

endinterface

// File: rtl/pwm_ramp_prescaler.sv
// Tick prescaler: one tick every div_i+1 enabled cycles, with synchronous restart.
module pwm_ramp_prescaler
    import pwm_ramp_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // >= rather than == so a divisor lowered below the running count ticks at once instead of wrapping.
    assign tick_o = en_i && (cnt_q >= div_i);

    // Next count: restart on clear, wrap on tick, advance while enabled, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_controller.sv
// Ramps the live PWM duty toward a programmed target one step per prescaled tick.
// Optional feature macro: PWM_RAMP_BYPASS_EN (cfg_valid with bypass=1 loads the target directly).
module pwm_ramp_controller
    import pwm_ramp_pkg::*;
#(
    parameter int unsigned DUTY_W = DUTY_W_DEF,
    parameter int unsigned DIV_W  = DIV_W_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pwm_ramp_controller_if.slave  rif
);

    localparam int unsigned AW = DUTY_W + 1;

    ramp_state_t       state_q;
    ramp_state_t       state_d;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_d;
    logic [DUTY_W-1:0] target_q;
    logic [DUTY_W-1:0] target_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;

    logic              run;
    logic              tick;
    logic              bypass_req;
    logic [AW-1:0]     step_ext;
    logic [AW-1:0]     gap_up;
    logic [AW-1:0]     gap_down;

`ifdef PWM_RAMP_BYPASS_EN
    assign bypass_req = rif.bypass;
`else
    assign bypass_req = 1'b0;
`endif

    // The prescaler only advances while a ramp is in progress and the engine is enabled.
    assign run = rif.enable && (state_q != IDLE);

    pwm_ramp_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (run),
        .clr_i  (rif.cfg_valid),
        .div_i  (rif.cfg_div),
        .tick_o (tick)
    );

    assign step_ext = (rif.cfg_step == '0) ? AW'(ZERO_STEP_SUBST) : AW'(rif.cfg_step);
    assign gap_up   = {1'b0, target_q} - {1'b0, duty_q};
    assign gap_down = {1'b0, duty_q} - {1'b0, target_q};

    // Next state and duty: a new configuration overrides any tick in the same cycle.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        done_d   = 1'b0;
        if (rif.cfg_valid) begin
            target_d = rif.cfg_target;
            if (bypass_req) begin
                duty_d  = rif.cfg_target;
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (rif.cfg_target > duty_q) begin
                state_d = RAMP_UP;
            end else if (rif.cfg_target < duty_q) begin
                state_d = RAMP_DOWN;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (tick) begin
            case (state_q)
                RAMP_UP: begin
                    if (gap_up <= step_ext) begin
                        duty_d  = target_q;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        duty_d = duty_q + step_ext[DUTY_W-1:0];
                    end
                end
                RAMP_DOWN: begin
                    if (gap_down <= step_ext) begin
                        duty_d  = target_q;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        duty_d = duty_q - step_ext[DUTY_W-1:0];
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State, duty and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            target_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign rif.duty_out = duty_q;
    assign rif.busy     = busy_q;
    assign rif.done     = done_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller with hand-computed expected duty sequences.
// Optional feature macro: PWM_RAMP_BYPASS_EN (enables the bypass scenario).
module tb_pwm_ramp_controller;

    logic clk;
    logic rst_n;
    int unsigned n_tests;
    int unsigned n_fail;

    pwm_ramp_controller_if #(.DUTY_W(8), .DIV_W(8), .STEP_W(4)) rif ();

    pwm_ramp_controller #(
        .DUTY_W (8),
        .DIV_W  (8),
        .STEP_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rif   (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] t, input logic [3:0] s, input logic [7:0] d);
        rif.cfg_valid  = 1'b1;
        rif.cfg_target = t;
        rif.cfg_step   = s;
        rif.cfg_div    = d;
        tick_clk();
        rif.cfg_valid  = 1'b0;
    endtask

    task automatic wait_done(input int unsigned bound);
        int unsigned n;
        n = 0;
        while (!rif.done && n < bound) begin
            tick_clk();
            n++;
        end
        check("wait_done", rif.done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] down_exp [3];
        logic [7:0] prev;
        n_tests = 0;
        n_fail  = 0;
        down_exp[0] = 8'h0B;
        down_exp[1] = 8'h06;
        down_exp[2] = 8'h03;

        rst_n          = 1'b0;
        rif.enable     = 1'b1;
        rif.cfg_valid  = 1'b0;
        rif.cfg_target = '0;
        rif.cfg_step   = '0;
        rif.cfg_div    = '0;
`ifdef PWM_RAMP_BYPASS_EN
        rif.bypass     = 1'b0;
`endif
        repeat (3) tick_clk();
        check("rst_duty", rif.duty_out, 8'h00);
        check("rst_busy", rif.busy, 1'b0);
        check("rst_done", rif.done, 1'b0);
        rst_n = 1'b1;
        tick_clk();
        check("idle_duty", rif.duty_out, 8'h00);

        // Ramp up 0x00 -> 0x10, step 4, tick every cycle.
        cfg(8'h10, 4'd4, 8'd0);
        check("up_busy_rise", rif.busy, 1'b1);
        check("up_duty_n1", rif.duty_out, 8'h00);
        check("up_done_n1", rif.done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick_clk();
            check("up_duty", rif.duty_out, 32'(4 * (i + 1)));
            check("up_done", rif.done, (i == 3) ? 1'b1 : 1'b0);
            check("up_busy", rif.busy, (i == 3) ? 1'b0 : 1'b1);
        end
        tick_clk();
        check("up_done_clear", rif.done, 1'b0);

        // Ramp down 0x10 -> 0x03, step 5, tick every third cycle, clamped final step.
        cfg(8'h03, 4'd5, 8'd2);
        check("dn_busy_rise", rif.busy, 1'b1);
        prev = 8'h10;
        for (int k = 0; k < 3; k++) begin
            for (int h = 0; h < 2; h++) begin
                tick_clk();
                check("dn_hold", rif.duty_out, prev);
                check("dn_hold_done", rif.done, 1'b0);
            end
            tick_clk();
            check("dn_duty", rif.duty_out, down_exp[k]);
            check("dn_done", rif.done, (k == 2) ? 1'b1 : 1'b0);
            prev = down_exp[k];
        end
        tick_clk();
        check("dn_done_clear", rif.done, 1'b0);
        check("dn_final", rif.duty_out, 8'h03);

        // Long ramp to 0xF0, then near-top targets with large and zero steps.
        cfg(8'hF0, 4'd15, 8'd0);
        wait_done(40);
        check("to_f0", rif.duty_out, 8'hF0);
        tick_clk();
        cfg(8'hFE, 4'd15, 8'd0);
        check("fe_busy", rif.busy, 1'b1);
        tick_clk();
        check("fe_duty", rif.duty_out, 8'hFE);
        check("fe_done", rif.done, 1'b1);
        check("fe_busy_fall", rif.busy, 1'b0);
        cfg(8'hFC, 4'd0, 8'd0);
        tick_clk();
        check("step0_a", rif.duty_out, 8'hFD);
        check("step0_a_done", rif.done, 1'b0);
        tick_clk();
        check("step0_b", rif.duty_out, 8'hFC);
        check("step0_b_done", rif.done, 1'b1);
        cfg(8'hFF, 4'd15, 8'd0);
        tick_clk();
        check("ff_duty", rif.duty_out, 8'hFF);
        check("ff_done", rif.done, 1'b1);

        // Retarget coinciding with a tick reverses direction without stepping.
        cfg(8'h40, 4'd15, 8'd0);
        wait_done(40);
        check("to_40", rif.duty_out, 8'h40);
        tick_clk();
        cfg(8'h80, 4'd8, 8'd1);
        tick_clk();
        tick_clk();
        check("rt_first_step", rif.duty_out, 8'h48);
        tick_clk();
        check("rt_pre", rif.duty_out, 8'h48);
        cfg(8'h20, 4'd8, 8'd1);
        check("rt_no_step", rif.duty_out, 8'h48);
        check("rt_busy", rif.busy, 1'b1);
        check("rt_no_done", rif.done, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick_clk();
            check("rt_hold", rif.duty_out, 32'(8'h48 - 8 * (k - 1)));
            check("rt_hold_done", rif.done, 1'b0);
            tick_clk();
            check("rt_duty", rif.duty_out, 32'(8'h48 - 8 * k));
            check("rt_done", rif.done, (k == 5) ? 1'b1 : 1'b0);
            check("rt_busyk", rif.busy, (k == 5) ? 1'b0 : 1'b1);
        end
        tick_clk();
        check("rt_done_clear", rif.done, 1'b0);

        // Target equal to current duty: immediate done, never busy.
        cfg(8'h20, 4'd3, 8'd0);
        check("eq_done", rif.done, 1'b1);
        check("eq_busy", rif.busy, 1'b0);
        check("eq_duty", rif.duty_out, 8'h20);
        tick_clk();
        check("eq_done_clear", rif.done, 1'b0);

        // Freeze mid-ramp with the prescaler part-way through a period.
        cfg(8'h30, 4'd4, 8'd1);
        tick_clk();
        tick_clk();
        check("fz_step1", rif.duty_out, 8'h24);
        tick_clk();
        rif.enable = 1'b0;
        repeat (10) tick_clk();
        check("fz_duty", rif.duty_out, 8'h24);
        check("fz_busy", rif.busy, 1'b1);
        check("fz_done", rif.done, 1'b0);
        rif.enable = 1'b1;
        tick_clk();
        check("fz_resume", rif.duty_out, 8'h28);
        tick_clk();
        tick_clk();
        check("fz_step3", rif.duty_out, 8'h2C);
        tick_clk();
        tick_clk();
        check("fz_final", rif.duty_out, 8'h30);
        check("fz_final_done", rif.done, 1'b1);
        tick_clk();

        // Asynchronous reset between clock edges mid-ramp.
        cfg(8'h80, 4'd1, 8'd3);
        repeat (4) tick_clk();
        check("ar_pre", rif.duty_out, 8'h31);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_duty", rif.duty_out, 8'h00);
        check("ar_busy", rif.busy, 1'b0);
        check("ar_done", rif.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_clk();
        check("ar_after_duty", rif.duty_out, 8'h00);
        check("ar_after_busy", rif.busy, 1'b0);

`ifdef PWM_RAMP_BYPASS_EN
        // Bypass loads the target directly.
        rif.bypass = 1'b1;
        cfg(8'h99, 4'd1, 8'd0);
        rif.bypass = 1'b0;
        check("bp_duty", rif.duty_out, 8'h99);
        check("bp_done", rif.done, 1'b1);
        check("bp_busy", rif.busy, 1'b0);
        tick_clk();
        check("bp_done_clear", rif.done, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
